// File: rtl/poly_mul_pkg.sv
// Shared sizing and FSM encoding for the polynomial multiplier I/O controller.
package poly_mul_pkg;
  localparam int N_COEFF     = 64;
  localparam int COEFF_WIDTH = 16;
  localparam int AB_ADDR_W   = $clog2(N_COEFF);
  localparam int C_ADDR_W    = AB_ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, CLEAR_C, START, WAIT, UNLOAD_RD, UNLOAD_OUT
  } state_t;
endpackage

// File: rtl/poly_mul_io_ctrl_if.sv
// Operand input stream and result output stream of the multiplier I/O controller.
interface poly_mul_io_ctrl_if import poly_mul_pkg::*; #(parameter int W = COEFF_WIDTH);
  // A word moves on a rising clk edge where valid && ready are both high; the
  // source keeps valid/data (and last) stable until that edge, and ready never waits on valid.
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;

  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, m_last);
  modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/poly_fold_out.sv
// Negacyclic fold (low half minus high half) and the output holding register.
module poly_fold_out import poly_mul_pkg::*; #(parameter int W = COEFF_WIDTH) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         ack,
  input  logic         last_in,
  input  logic [W-1:0] rdata0,
  input  logic [W-1:0] rdata1,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  output logic         m_last
);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_data  <= rdata0 - rdata1;
      m_valid <= 1'b1;
      m_last  <= last_in;
    end else if (ack) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end
endmodule

// File: rtl/poly_mul_io_ctrl.sv
// Loads operands A/B into RAM, clears C, runs the multiplier and streams out the folded result.
module poly_mul_io_ctrl #(
  parameter  int N_COEFF     = poly_mul_pkg::N_COEFF,
  parameter  int COEFF_WIDTH = poly_mul_pkg::COEFF_WIDTH,
  localparam int AW          = $clog2(N_COEFF),
  localparam int CW          = AW + 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  poly_mul_io_ctrl_if.slave      bus,
  output logic                   a_we,
  output logic [AW-1:0]          a_addr,
  output logic [COEFF_WIDTH-1:0] a_wdata,
  output logic                   b_we,
  output logic [AW-1:0]          b_addr,
  output logic [COEFF_WIDTH-1:0] b_wdata,
  output logic                   c_we,
  output logic [CW-1:0]          c_addr,
  output logic [COEFF_WIDTH-1:0] c_wdata,
  output logic [CW-1:0]          c_raddr0,
  output logic [CW-1:0]          c_raddr1,
  input  logic [COEFF_WIDTH-1:0] c_rdata0,
  input  logic [COEFF_WIDTH-1:0] c_rdata1,
  output logic                   mul_start,
  input  logic                   mul_done,
  output logic                   mul_own,
  output logic                   busy,
  output poly_mul_pkg::state_t   state_dbg
);
  import poly_mul_pkg::*;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [AW-1:0] i_q, i_n;
  logic          s_ready;
  logic          fold_load;
  logic          m_ack;
  logic          rd_active;
  logic [AW-1:0] rd_idx;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      i_q     <= i_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    i_n       = i_q;
    s_ready   = 1'b0;
    a_we      = 1'b0;
    a_addr    = '0;
    a_wdata   = '0;
    b_we      = 1'b0;
    b_addr    = '0;
    b_wdata   = '0;
    c_we      = 1'b0;
    c_addr    = '0;
    c_wdata   = '0;
    mul_start = 1'b0;
    mul_own   = 1'b0;
    fold_load = 1'b0;
    m_ack     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_n = '0;
        i_n   = '0;
        if (bus.s_valid) state_n = LOAD_A;
      end
      LOAD_A: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
          a_we    = 1'b1;
          a_addr  = cnt_q[AW-1:0];
          a_wdata = bus.s_data;
          if (cnt_q == CW'(N_COEFF - 1)) begin
            state_n = LOAD_B;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
      end
      LOAD_B: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
          b_we    = 1'b1;
          b_addr  = cnt_q[AW-1:0];
          b_wdata = bus.s_data;
          if (cnt_q == CW'(N_COEFF - 1)) begin
            state_n = CLEAR_C;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
      end
      CLEAR_C: begin
        c_we   = 1'b1;
        c_addr = cnt_q;
        if (cnt_q == CW'(2 * N_COEFF - 1)) begin
          state_n = START;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      START: begin
        mul_start = 1'b1;
        mul_own   = 1'b1;
        state_n   = WAIT;
      end
      WAIT: begin
        mul_own = 1'b1;
        if (mul_done) begin
          state_n = UNLOAD_RD;
          i_n     = '0;
        end
      end
      UNLOAD_RD: begin
        fold_load = 1'b1;
        state_n   = UNLOAD_OUT;
      end
      UNLOAD_OUT: begin
        if (bus.m_ready) begin
          m_ack = 1'b1;
          if (i_q == AW'(N_COEFF - 1)) begin
            state_n = IDLE;
            i_n     = '0;
          end else begin
            state_n = UNLOAD_RD;
            i_n     = i_q + AW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The read address goes out one cycle ahead of UNLOAD_RD and stays through it, so the
  // one-cycle RAM data is valid in UNLOAD_RD and folds in on the edge into UNLOAD_OUT.
  always_comb begin
    rd_active = 1'b0;
    rd_idx    = '0;
    if (state_n == UNLOAD_RD) begin
      rd_active = 1'b1;
      rd_idx    = i_n;
    end else if (state_q == UNLOAD_RD) begin
      rd_active = 1'b1;
      rd_idx    = i_q;
    end
  end

  // N_COEFF is a power of two, so the high-half partner i+N_COEFF is just the top address bit.
  assign c_raddr0    = rd_active ? {1'b0, rd_idx} : '0;
  assign c_raddr1    = rd_active ? {1'b1, rd_idx} : '0;
  assign bus.s_ready = s_ready;
  assign busy        = (state_q != IDLE);
  assign state_dbg   = state_q;

  poly_fold_out #(.W(COEFF_WIDTH)) u_fold (
    .clk     (clk),
    .resetn  (resetn),
    .load    (fold_load),
    .ack     (m_ack),
    .last_in (i_q == AW'(N_COEFF - 1)),
    .rdata0  (c_rdata0),
    .rdata1  (c_rdata1),
    .m_data  (bus.m_data),
    .m_valid (bus.m_valid),
    .m_last  (bus.m_last)
  );
endmodule

// File: tb/tb_poly_mul_io_ctrl.sv
// Bench for poly_mul_io_ctrl: RAM and multiplier models, stream drivers, result scoreboard.
module tb_poly_mul_io_ctrl;
  import poly_mul_pkg::*;
  localparam int N = 64;
  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  initial forever #5 clk = ~clk;

  poly_mul_io_ctrl_if #(.W(W)) bus ();
  logic         a_we, b_we, c_we, mul_start, mul_done, mul_own, busy;
  logic [5:0]   a_addr, b_addr;
  logic [6:0]   c_addr, c_raddr0, c_raddr1;
  logic [W-1:0] a_wdata, b_wdata, c_wdata, c_rdata0, c_rdata1;
  state_t       state_dbg;
  logic         mul_done_q = 1'b0;
  logic         spur_done = 1'b0;
  assign mul_done = mul_done_q | spur_done;

  poly_mul_io_ctrl dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_raddr0(c_raddr0), .c_raddr1(c_raddr1), .c_rdata0(c_rdata0), .c_rdata1(c_rdata1),
    .mul_start(mul_start), .mul_done(mul_done), .mul_own(mul_own),
    .busy(busy), .state_dbg(state_dbg)
  );

  // RAMs (1-cycle read) and a behavioural schoolbook multiplier writing the full product into C
  logic [W-1:0]   a_mem [N];
  logic [W-1:0]   b_mem [N];
  logic [W-1:0]   c_mem [2*N];
  logic [2*W-1:0] prod;
  int             done_ctr = 0;
  int             mul_lat = 12;
  always @(posedge clk) begin
    c_rdata0 <= c_mem[c_raddr0];
    c_rdata1 <= c_mem[c_raddr1];
    if (a_we) a_mem[a_addr] <= a_wdata;
    if (b_we) b_mem[b_addr] <= b_wdata;
    if (c_we) c_mem[c_addr] = c_wdata;
    mul_done_q <= 1'b0;
    if (done_ctr != 0) begin
      done_ctr <= done_ctr - 1;
      if (done_ctr == 1) mul_done_q <= 1'b1;
    end
    if (mul_start) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          prod = a_mem[i] * b_mem[j];
          c_mem[i+j] = c_mem[i+j] + prod[W-1:0];
        end
      done_ctr <= mul_lat;
    end
  end

  // scoreboard
  logic [W:0]   exp_q [$];
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  int vectors = 0;
  int errors = 0;
  bit rdy_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: product reduced modulo x^N + 1
  task automatic push_model();
    logic [W-1:0]   r [N];
    logic [2*W-1:0] p;
    for (int k = 0; k < N; k++) r[k] = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        p = op_a[i] * op_b[j];
        if (i + j < N) r[i+j] = r[i+j] + p[W-1:0];
        else           r[i+j-N] = r[i+j-N] - p[W-1:0];
      end
    for (int k = 0; k < N; k++) exp_q.push_back({k == N - 1, r[k]});
  endtask

  // monitor: RAM write ordering, ownership, idle bus, output stream
  int a_cnt = 0, b_cnt = 0, c_cnt = 0, start_cnt = 0, cyc = 0, last_hs = 0;
  int a_exp = 0, b_exp = 0, c_exp = 0;
  bit prev_stall = 0, have_prev = 0, prev_last = 0, stall_last = 0;
  logic [W-1:0] stall_data = '0;
  logic [W:0]   e;
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      a_exp = 0; b_exp = 0; c_exp = 0;
      prev_stall = 0; have_prev = 0;
    end else begin
      if (a_we) begin
        check("a_addr", 32'(a_addr), 32'(a_exp));
        check("a_wdata", 32'(a_wdata), 32'(op_a[a_exp]));
        a_exp = (a_exp + 1) % N; a_cnt++;
      end
      if (b_we) begin
        check("b_addr", 32'(b_addr), 32'(b_exp));
        check("b_wdata", 32'(b_wdata), 32'(op_b[b_exp]));
        b_exp = (b_exp + 1) % N; b_cnt++;
      end
      if (c_we) begin
        check("c_addr", 32'(c_addr), 32'(c_exp));
        check("c_wdata", 32'(c_wdata), 32'(0));
        c_exp = (c_exp + 1) % (2 * N); c_cnt++;
      end
      if (mul_start) start_cnt++;
      if (mul_own) check("own_we", 32'({a_we, b_we, c_we}), 32'(0));
      if (!busy)
        check("idle_bus", 32'(|{a_addr, a_wdata, b_addr, b_wdata, c_addr, c_wdata, c_raddr0,
                                c_raddr1, a_we, b_we, c_we, mul_start, mul_own, bus.s_ready}), 32'(0));
      if (prev_stall) begin
        check("hold_valid", 32'(bus.m_valid), 32'(1));
        check("hold_data", 32'(bus.m_data), 32'(stall_data));
        check("hold_last", 32'(bus.m_last), 32'(stall_last));
      end
      if (bus.m_valid && bus.m_ready) begin
        check("out_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("m_data", 32'(bus.m_data), 32'(e[W-1:0]));
          check("m_last", 32'(bus.m_last), 32'(e[W]));
          if (have_prev && !prev_last && !rdy_mode) check("out_gap", 32'(cyc - last_hs), 32'(2));
          have_prev = 1; prev_last = e[W]; last_hs = cyc;
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
      stall_last = bus.m_last;
    end
  end

  // output-side ready: always high, or a fair coin per cycle
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.m_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [W-1:0] d);
    int guard = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (!bus.s_ready && guard < 50) begin tick(); guard++; end
    if (guard >= 50) check("s_ready_timeout", 32'(bus.s_ready), 32'(1));
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic load_ops(input bit spur);
    for (int k = 0; k < N; k++) send_word(op_a[k]);
    for (int k = 0; k < N; k++) begin
      if (spur && k == 10) begin
        spur_done = 1'b1; tick(); spur_done = 1'b0;
        check("spur_state", 32'(state_dbg), 32'(LOAD_B));
      end
      send_word(op_b[k]);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || exp_q.size() != 0) && guard < 3000) begin tick(); guard++; end
    if (guard >= 3000) begin
      check("idle_timeout_busy", 32'(busy), 32'(0));
      check("idle_timeout_left", 32'(exp_q.size()), 32'(0));
    end
  endtask

  int a_base, b_base, c_base, s_base;
  task automatic snap();
    a_base = a_cnt; b_base = b_cnt; c_base = c_cnt; s_base = start_cnt;
  endtask

  task automatic check_counts();
    check("a_writes", 32'(a_cnt - a_base), 32'(N));
    check("b_writes", 32'(b_cnt - b_base), 32'(N));
    check("c_writes", 32'(c_cnt - c_base), 32'(2 * N));
    check("mul_starts", 32'(start_cnt - s_base), 32'(1));
  endtask

  task automatic run_load(input bit spur);
    snap();
    load_ops(spur);
    wait_idle();
    check_counts();
  endtask

  task automatic random_ops();
    for (int k = 0; k < N; k++) begin
      op_a[k] = W'($urandom_range(0, 65535));
      op_b[k] = W'($urandom_range(0, 65535));
    end
  endtask

  initial begin
    int guard;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) tick();
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_s_ready", 32'(bus.s_ready), 32'(0));
    check("rst_m_valid", 32'(bus.m_valid), 32'(0));
    check("rst_m_last", 32'(bus.m_last), 32'(0));
    check("rst_m_data", 32'(bus.m_data), 32'(0));
    check("rst_mul", 32'({mul_start, mul_own}), 32'(0));
    check("rst_we", 32'({a_we, b_we, c_we}), 32'(0));
    resetn = 1'b1;
    tick();

    // ramp operands A[k]=k, B[k]=2k
    for (int k = 0; k < N; k++) begin op_a[k] = W'(k); op_b[k] = W'(2 * k); end
    push_model();
    run_load(1'b0);

    // x^63 * x = x^64 = -1 mod x^64+1
    for (int k = 0; k < N; k++) begin op_a[k] = '0; op_b[k] = '0; end
    op_a[N-1] = W'(1); op_b[1] = W'(1);
    for (int k = 0; k < N; k++) exp_q.push_back({k == N - 1, (k == 0) ? 16'hFFFF : 16'h0000});
    run_load(1'b0);

    // unit A passes B through
    for (int k = 0; k < N; k++) begin op_a[k] = '0; op_b[k] = W'(k + 1); end
    op_a[0] = W'(1);
    for (int k = 0; k < N; k++) exp_q.push_back({k == N - 1, 16'(k + 1)});
    run_load(1'b0);

    // random operands with a randomly stalling sink
    rdy_mode = 1'b1;
    random_ops();
    push_model();
    run_load(1'b0);
    rdy_mode = 1'b0;
    tick();

    // reset part-way through A, then a fresh full load
    random_ops();
    for (int k = 0; k < 30; k++) send_word(op_a[k]);
    resetn = 1'b0;
    tick();
    check("midrst_state", 32'(state_dbg), 32'(IDLE));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_s_ready", 32'(bus.s_ready), 32'(0));
    resetn = 1'b1;
    tick();
    random_ops();
    push_model();
    run_load(1'b0);

    // spurious mul_done in LOAD_B, s_valid asserted during WAIT
    mul_lat = 20;
    random_ops();
    push_model();
    snap();
    load_ops(1'b1);
    guard = 0;
    while (state_dbg != WAIT && guard < 400) begin tick(); guard++; end
    check("reach_wait", 32'(state_dbg), 32'(WAIT));
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h5A5A;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("wait_s_ready", 32'(bus.s_ready), 32'(0));
      check("wait_state", 32'(state_dbg), 32'(WAIT));
    end
    bus.s_valid = 1'b0;
    wait_idle();
    check_counts();
    mul_lat = 12;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/poly_mul_io_ctrl.md
POLY_MUL_IO_CTRL -- requirements
Module: poly_mul_io_ctrl

Interface
REQ-001 SHALL have parameter N_COEFF, default 64, number of coefficients per operand polynomial.
REQ-002 SHALL have parameter COEFF_WIDTH, default 16, coefficient width in bits.
REQ-003 SHALL have ports clk (in, 1, clock) and resetn (in, 1, reset); reset resetn is synchronous, active-low, and the clock is clk.
REQ-004 SHALL have input stream ports s_valid (in, 1), s_ready (out, 1) and s_data (in, 16), carrying operand coefficients.
REQ-005 SHALL have output stream ports m_valid (out, 1), m_ready (in, 1), m_data (out, 16) and m_last (out, 1), carrying result coefficients.
REQ-006 SHALL have A RAM write ports a_we (out, 1), a_addr (out, 6) and a_wdata (out, 16).
REQ-007 SHALL have B RAM write ports b_we (out, 1), b_addr (out, 6) and b_wdata (out, 16).
REQ-008 SHALL have C RAM write ports c_we (out, 1), c_addr (out, 7) and c_wdata (out, 16).
REQ-009 SHALL have C RAM read ports c_raddr0 (out, 7), c_raddr1 (out, 7), c_rdata0 (in, 16) and c_rdata1 (in, 16); read latency is 1 cycle.
REQ-010 SHALL have multiplier ports mul_start (out, 1, one-cycle pulse), mul_done (in, 1, one-cycle pulse) and mul_own (out, 1, high = RAM ports granted to the multiplier).
REQ-011 SHALL have output busy (out, 1), high in every state except IDLE.

Function
REQ-012 SHALL implement the states IDLE, LOAD_A, LOAD_B, CLEAR_C, START, WAIT, UNLOAD_RD, UNLOAD_OUT.
REQ-013 SHALL transition from IDLE to LOAD_A on the first cycle with s_valid=1; IDLE itself accepts no data.
REQ-014 SHALL, in LOAD_A and LOAD_B, drive s_ready=1 and on each handshake write s_data to a_addr/b_addr = cnt with a_we/b_we=1 in the same cycle, then increment cnt.
REQ-015 SHALL move LOAD_A to LOAD_B after handshake N_COEFF-1, and LOAD_B to CLEAR_C after handshake N_COEFF-1; cnt wraps to 0 on each change.
REQ-016 SHALL hold s_ready=0 in all other states, ignoring s_valid there.
REQ-017 SHALL, in CLEAR_C, write 0 to c_addr = 0..127 (one per cycle, c_we=1), taking 128 cycles, then go to START.
REQ-018 SHALL, in START, assert mul_start=1 for exactly one cycle and go to WAIT; mul_own SHALL be 1 during START and WAIT only.
REQ-019 SHALL leave WAIT for UNLOAD_RD in the cycle after mul_done=1 is sampled; mul_done in any other state is ignored.
REQ-020 SHALL, in UNLOAD_RD, drive c_raddr0 = i and c_raddr1 = i+64 (i = 0..63) and then go to UNLOAD_OUT.
REQ-021 SHALL, on entry to UNLOAD_OUT, register m_data = (c_rdata0 - c_rdata1) mod 2^16 (negacyclic fold for x^64+1) and set m_valid=1.
REQ-022 SHALL hold m_data and m_valid stable until m_ready=1, then increment i and return to UNLOAD_RD; after i=63 it SHALL return to IDLE.
REQ-023 SHALL assert m_last with the i=63 word only.
REQ-024 SHALL give a throughput of 1 result per 2 cycles when m_ready is held at 1.
REQ-025 SHALL hold all write enables and mul_start at 0 whenever mul_own=1, and drive zero on all addresses and data when idle.

Reset
REQ-026 SHALL, when resetn=0 at a clock edge (including mid-operation), go to IDLE with cnt=0, i=0, and s_ready, m_valid, m_last, m_data, mul_start, mul_own, busy, a_we, b_we and c_we all 0.
REQ-027 SHALL treat a partially loaded operand as discarded after reset; the next load restarts at address 0.

Structure
REQ-028 SHALL place N_COEFF, COEFF_WIDTH, the address widths and the state encoding (3-bit enumerated) in shared package poly_mul_pkg.
REQ-029 SHALL use one sub-module, poly_fold_out, containing the subtract-mod-2^16 logic and the m_data/m_valid/m_last holding register.

Verification
REQ-030 SHALL drive 128 words with no gaps: A[k]=k, B[k]=2k -> a_we/b_we pulses at addresses 0..63 each, then 128 c_we writes of 0, then one mul_start pulse.
REQ-031 SHALL use a behavioural multiplier model with A = x^63, B = x -> outputs m_data[0]=0xFFFF, all others 0, and m_last on word 63.
REQ-032 SHALL use A=1 (only A[0]=1) and B[k]=k+1 -> m_data[k] = k+1 for k = 0..63.
REQ-033 SHALL toggle m_ready at random with 50% duty -> all 64 words delivered in order, m_data stable while m_valid=1 and m_ready=0.
REQ-034 SHALL assert resetn=0 after 30 A words, then send a full new load -> writes restart at a_addr=0 and the result matches the new operands.
REQ-035 SHALL inject a spurious mul_done during LOAD_B and assert s_valid during WAIT -> no state change and s_ready=0.
